// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM states, write-back selects,
// and the control half of the MEM/WB payload.
package mem_stage_pkg;

  typedef enum logic {
    MS_IDLE,
    MS_REQ
  } ms_state_t;

  localparam logic [1:0] MM_ALU  = 2'b00;
  localparam logic [1:0] MM_LOAD = 2'b01;

  typedef struct packed {
    logic       wbs;
    logic [1:0] mm;
    logic       ni;
    logic [2:0] side;
  } mw_ctrl_t;

  function automatic logic is_load(input logic [1:0] mm);
    return mm == MM_LOAD;
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory req/ack bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_access_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Cycle counter with clear/enable; tc flags the last allowed
// request cycle before a forced completion.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_stage_access.sv
// Memory stage: runs the data-memory transaction for loads/stores,
// stalls upstream while it is pending, and registers the MEM/WB payload.
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbs_in,
  input  logic [1:0]        mm_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] memdata_in,
  input  logic              wm_in,
  input  logic              ni_in,
  input  logic [2:0]        side_in,
  mem_stage_access_if.master dmem,
  output logic              stall_out,
  output logic              valid_out,
  output logic              wbs_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [1:0]        mm_out,
  output logic              ni_out,
  output logic [2:0]        side_out,
  output logic              err_out
);
  ms_state_t         state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] alu_q;
  mw_ctrl_t          ctl_q;

  logic              valid_q;
  mw_ctrl_t          out_q;
  logic [DATA_W-1:0] wbd_q;
  logic              err_q;

  logic              access;
  logic              latch;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;
  logic              err_set;
  logic              stall;
  logic              nvalid;
  mw_ctrl_t          nctl;
  logic [DATA_W-1:0] ndata;
  logic [DATA_W-1:0] rd_eff;

  mem_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  assign access = wm_in | is_load(mm_in);
  // A timed-out read completes with zero data
  assign rd_eff = dmem.ack ? dmem.rdata : '0;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    err_set = 1'b0;
    nvalid  = 1'b0;
    nctl    = '0;
    ndata   = '0;
    unique case (state_q)
      MS_IDLE: begin
        if (access) begin
          stall   = 1'b1;
          latch   = 1'b1;
          cnt_clr = 1'b1;
          state_d = MS_REQ;
        end else begin
          nvalid = 1'b1;
          nctl   = '{wbs: wbs_in, mm: mm_in,
                     ni: ni_in, side: side_in};
          ndata  = alu_in;
        end
      end
      MS_REQ: begin
        if (dmem.ack || cnt_tc) begin
          state_d = MS_IDLE;
          nvalid  = 1'b1;
          nctl    = ctl_q;
          err_set = ~dmem.ack;
          if (we_q)
            ndata = '0;
          else if (is_load(ctl_q.mm))
            ndata = rd_eff;
          else
            ndata = alu_q;
        end else begin
          stall  = 1'b1;
          cnt_en = 1'b1;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      ctl_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      wbd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        we_q    <= wm_in;
        addr_q  <= alu_in[ADDR_W-1:0];
        wdata_q <= memdata_in;
        alu_q   <= alu_in;
        ctl_q   <= '{wbs: wbs_in, mm: mm_in,
                     ni: ni_in, side: side_in};
      end
      valid_q <= nvalid;
      out_q   <= nctl;
      wbd_q   <= ndata;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign dmem.req   = (state_q == MS_REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  assign stall_out   = stall;
  assign valid_out   = valid_q;
  assign wbs_out     = out_q.wbs;
  assign wb_data_out = wbd_q;
  assign mm_out      = out_q.mm;
  assign ni_out      = out_q.ni;
  assign side_out    = out_q.side;
  assign err_out     = err_q;
endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: table of single-cycle ALU ops
// plus hand-written load/store/timeout/reset sequences.
module tb_mem_stage_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_in;
  logic [1:0]  mm_in;
  logic [15:0] alu_in;
  logic [15:0] memdata_in;
  logic        wm_in;
  logic        ni_in;
  logic [2:0]  side_in;
  logic        stall_out;
  logic        valid_out;
  logic        wbs_out;
  logic [15:0] wb_data_out;
  logic [1:0]  mm_out;
  logic        ni_out;
  logic [2:0]  side_out;
  logic        err_out;

  int errs = 0;
  int checks = 0;

  mem_stage_access_if #(.DATA_W(16), .ADDR_W(16)) dmem ();

  mem_stage_access #(
    .DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wbs_in     (wbs_in),
    .mm_in      (mm_in),
    .alu_in     (alu_in),
    .memdata_in (memdata_in),
    .wm_in      (wm_in),
    .ni_in      (ni_in),
    .side_in    (side_in),
    .dmem       (dmem),
    .stall_out  (stall_out),
    .valid_out  (valid_out),
    .wbs_out    (wbs_out),
    .wb_data_out(wb_data_out),
    .mm_out     (mm_out),
    .ni_out     (ni_out),
    .side_out   (side_out),
    .err_out    (err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wbs, input logic [1:0] mm,
                       input logic [15:0] alu, input logic [15:0] md,
                       input logic wm, input logic ni,
                       input logic [2:0] side);
    wbs_in = wbs; mm_in = mm; alu_in = alu;
    memdata_in = md; wm_in = wm; ni_in = ni; side_in = side;
  endtask

  task automatic nop();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 3'b000);
  endtask

  // ack_at = REQ cycle carrying the ack (1-based); 0 = never
  task automatic do_access(input logic wm, input logic [1:0] mm,
                           input logic [15:0] alu, input logic [15:0] md,
                           input int ack_at, input logic [15:0] rd,
                           input logic [15:0] exp_data,
                           input logic exp_err);
    bit done;
    done = 1'b0;
    drive(1'b1, mm, alu, md, wm, 1'b1, 3'b101);
    dmem.ack = 1'b0; dmem.rdata = 16'h0;
    #1;
    chk("idle_stall", stall_out, 1);
    chk("idle_req", dmem.req, 0);
    tick();
    for (int c = 1; c <= 15 && !done; c++) begin
      chk("req_held", dmem.req, 1);
      chk("req_addr", dmem.addr, alu);
      chk("req_we", dmem.we, wm);
      chk("req_wdata", dmem.wdata, md);
      chk("req_bubble_valid", valid_out, 0);
      chk("req_bubble_wbs", wbs_out, 0);
      done = (c == ack_at) || (ack_at == 0 && c == 15);
      if (c == ack_at) begin
        dmem.ack = 1'b1; dmem.rdata = rd;
      end
      #1;
      chk("req_stall", stall_out, !done);
      tick();
      dmem.ack = 1'b0; dmem.rdata = 16'h0;
    end
    chk("done_req", dmem.req, 0);
    chk("done_valid", valid_out, 1);
    chk("done_wbs", wbs_out, 1);
    chk("done_data", wb_data_out, exp_data);
    chk("done_mm", mm_out, mm);
    chk("done_ni", ni_out, 1);
    chk("done_side", side_out, 3'b101);
    chk("done_err", err_out, exp_err);
  endtask

  typedef struct {
    logic        wbs;
    logic [1:0]  mm;
    logic [15:0] alu;
    logic        ni;
    logic [2:0]  side;
    logic [15:0] exp;
  } vec_t;

  vec_t v[5];

  initial begin
    v[0] = '{1'b1, 2'b00, 16'h1234, 1'b0, 3'b000, 16'h1234};
    v[1] = '{1'b0, 2'b10, 16'hABCD, 1'b1, 3'b111, 16'hABCD};
    v[2] = '{1'b1, 2'b11, 16'hFFFF, 1'b0, 3'b010, 16'hFFFF};
    v[3] = '{1'b1, 2'b00, 16'h0000, 1'b1, 3'b100, 16'h0000};
    v[4] = '{1'b0, 2'b00, 16'h8001, 1'b0, 3'b001, 16'h8001};

    rst = 1'b1;
    nop();
    dmem.ack = 1'b0; dmem.rdata = 16'h0;
    tick();
    tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_wbs", wbs_out, 0);
    chk("rst_data", wb_data_out, 0);
    chk("rst_req", dmem.req, 0);
    chk("rst_we", dmem.we, 0);
    chk("rst_addr", dmem.addr, 0);
    chk("rst_err", err_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(v[i].wbs, v[i].mm, v[i].alu, 16'h5A5A,
            1'b0, v[i].ni, v[i].side);
      #1;
      chk("alu_stall", stall_out, 0);
      chk("alu_req", dmem.req, 0);
      tick();
      chk("alu_valid", valid_out, 1);
      chk("alu_wbs", wbs_out, v[i].wbs);
      chk("alu_data", wb_data_out, v[i].exp);
      chk("alu_mm", mm_out, v[i].mm);
      chk("alu_ni", ni_out, v[i].ni);
      chk("alu_side", side_out, v[i].side);
    end

    // load, ack on 3rd REQ cycle
    do_access(1'b0, 2'b01, 16'h0040, 16'h5555, 3, 16'hBEEF,
              16'hBEEF, 1'b0);
    // store, ack on 1st REQ cycle; read data ignored
    do_access(1'b1, 2'b00, 16'h0010, 16'h00AA, 1, 16'hFFFF,
              16'h0000, 1'b0);
    // store and load select together: store wins
    do_access(1'b1, 2'b01, 16'h0020, 16'h0033, 2, 16'h1234,
              16'h0000, 1'b0);
    // load with immediate ack followed by an ALU op
    do_access(1'b0, 2'b01, 16'h0100, 16'h0000, 1, 16'hC0DE,
              16'hC0DE, 1'b0);
    drive(1'b1, 2'b00, 16'h0007, 16'h0, 1'b0, 1'b0, 3'b011);
    #1;
    chk("b2b_stall", stall_out, 0);
    tick();
    chk("b2b_valid", valid_out, 1);
    chk("b2b_data", wb_data_out, 16'h0007);
    chk("b2b_side", side_out, 3'b011);
    // ack on the terminal cycle: ack wins, no error
    do_access(1'b0, 2'b01, 16'h0044, 16'h0000, 15, 16'h7777,
              16'h7777, 1'b0);
    // no ack at all: forced completion, error set
    do_access(1'b0, 2'b01, 16'h0048, 16'h0000, 0, 16'h0000,
              16'h0000, 1'b1);
    nop();
    tick();
    chk("err_sticky", err_out, 1);
    chk("err_next_valid", valid_out, 1);

    // reset during the 2nd REQ cycle
    drive(1'b1, 2'b01, 16'h0050, 16'h0, 1'b0, 1'b1, 3'b111);
    tick();
    tick();
    chk("r5_req_before", dmem.req, 1);
    rst = 1'b1;
    tick();
    chk("r5_req", dmem.req, 0);
    chk("r5_valid", valid_out, 0);
    chk("r5_data", wb_data_out, 0);
    chk("r5_side", side_out, 0);
    chk("r5_err", err_out, 0);
    rst = 1'b0;
    // late ack lands in IDLE and must be ignored
    dmem.ack = 1'b1; dmem.rdata = 16'hDEAD;
    #1;
    chk("r5_idle_stall", stall_out, 1);
    tick();
    dmem.ack = 1'b0; dmem.rdata = 16'h0;
    chk("r5_ack_valid", valid_out, 0);
    chk("r5_req_again", dmem.req, 1);
    tick();
    chk("r5_still_req", dmem.req, 1);
    chk("r5_still_bubble", valid_out, 0);
    dmem.ack = 1'b1; dmem.rdata = 16'h0BAD;
    tick();
    dmem.ack = 1'b0; dmem.rdata = 16'h0;
    nop();
    chk("r5_fin_valid", valid_out, 1);
    chk("r5_fin_data", wb_data_out, 16'h0BAD);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
